// File: rtl/swc_pkg.sv
//==============================================================================
// Module      : swc_pkg
// Description : Shared types, ptr field layout and helpers for the ingress packer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package swc_pkg;

    localparam int PTR_PORTMAP_HI = 11;
    localparam int PTR_PORTMAP_LO = 8;
    localparam int PTR_WCNT_HI    = 7;
    localparam int PTR_WCNT_LO    = 0;
    localparam int CELL_WORDS     = 4;
    localparam int LANES          = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PACK    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    // One pending switch-core write: optional data word and optional descriptor.
    typedef struct packed {
        logic         dvld;
        logic [127:0] data;
        logic         pvld;
        logic [15:0]  ptr;
    } wr_item_t;

    function automatic logic [15:0] make_ptr(input logic [3:0] portmap,
                                             input logic [7:0] wcnt);
        logic [15:0] p;
        p = '0;
        p[PTR_PORTMAP_HI:PTR_PORTMAP_LO] = portmap;
        p[PTR_WCNT_HI:PTR_WCNT_LO]       = wcnt;
        return p;
    endfunction

    function automatic logic [127:0] lane_put(input logic [127:0] word,
                                              input logic [3:0]   idx,
                                              input logic [7:0]   b);
        logic [127:0] w;
        w = word;
        for (int k = 0; k < LANES; k++) begin
            if (idx == 4'(k)) begin
                w[127-8*k -: 8] = b;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/swc_ingress_packer_if.sv
//==============================================================================
// Module      : swc_ingress_packer_if
// Description : Byte-stream ingress, switch-core write and statistics bundle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface swc_ingress_packer_if;

    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_sop;
    logic         in_eop;
    logic [3:0]   in_portmap;
    logic [127:0] cell_data_din;
    logic         cell_data_wr;
    logic [15:0]  cell_ptr_din;
    logic         cell_ptr_wr;
    logic         cell_bp;
    logic [15:0]  stat_frame_cnt;
    logic [15:0]  stat_drop_cnt;
    logic [15:0]  stat_trunc_cnt;
    logic [15:0]  stat_err_cnt;

    // Stream source / switch-core side
    modport master (
        output in_data, in_valid, in_sop, in_eop, in_portmap, cell_bp,
        input  cell_data_din, cell_data_wr, cell_ptr_din, cell_ptr_wr,
        input  stat_frame_cnt, stat_drop_cnt, stat_trunc_cnt, stat_err_cnt
    );

    // Packer side
    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_portmap, cell_bp,
        output cell_data_din, cell_data_wr, cell_ptr_din, cell_ptr_wr,
        output stat_frame_cnt, stat_drop_cnt, stat_trunc_cnt, stat_err_cnt
    );

endinterface

`default_nettype wire

// File: rtl/swc_stat_cnt.sv
//==============================================================================
// Module      : swc_stat_cnt
// Description : 16-bit event counter that saturates at 16'hFFFF.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module swc_stat_cnt (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        inc_i,
    output logic [15:0]      cnt_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/swc_ingress_packer.sv
//==============================================================================
// Module      : swc_ingress_packer
// Description : Packs a byte stream into 128-bit cell words plus a frame descriptor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module swc_ingress_packer
    import swc_pkg::*;
#(
    parameter int MAX_WORDS = 96
) (
    input  wire logic           clk,
    input  wire logic           rst,
    swc_ingress_packer_if.slave bus
);

    localparam logic [7:0] c_max_words = 8'(MAX_WORDS);

    state_t       state_q, state_d;
    logic [3:0]   portmap_q, portmap_d;
    logic [3:0]   byte_idx_q, byte_idx_d;
    logic [7:0]   wcnt_q, wcnt_d;
    logic [127:0] word_q, word_d;
    logic         trunc_q, trunc_d;
    wr_item_t     pend_q, pend_d;
    wr_item_t     out_q, out_d;

    wr_item_t     w_close;
    wr_item_t     w_word_wr;
    logic [127:0] w_packed;
    logic         w_sop;
    logic         w_sop_ok;
    logic         w_close_vld;
    logic         w_word_vld;
    logic         w_pend_vld;
    logic         w_err_inc;
    logic         w_drop_inc;
    logic         w_trunc_inc;

    assign w_sop    = bus.in_valid & bus.in_sop;
    assign w_sop_ok = w_sop & ~bus.cell_bp & (bus.in_portmap != 4'd0);
    assign w_packed = lane_put(word_q, byte_idx_q, bus.in_data);

    always_comb begin
        state_d     = state_q;
        portmap_d   = portmap_q;
        byte_idx_d  = byte_idx_q;
        wcnt_d      = wcnt_q;
        word_d      = word_q;
        trunc_d     = trunc_q;
        w_close     = '0;
        w_word_wr   = '0;
        w_err_inc   = 1'b0;
        w_drop_inc  = 1'b0;
        w_trunc_inc = 1'b0;

        if (w_sop) begin
            // An sop while a frame is open closes it as if eop had been seen
            if (state_q == ST_PACK) begin
                w_close.dvld = (byte_idx_q != 4'd0);
                w_close.data = word_q;
                w_close.pvld = 1'b1;
                w_close.ptr  = make_ptr(portmap_q,
                                        (byte_idx_q != 4'd0) ? wcnt_q + 8'd1 : wcnt_q);
            end
            w_err_inc  = (state_q != ST_IDLE);
            word_d     = '0;
            byte_idx_d = '0;
            wcnt_d     = '0;
            trunc_d    = 1'b0;
            if (w_sop_ok) begin
                if (bus.in_eop) begin
                    w_word_wr.dvld = 1'b1;
                    w_word_wr.data = {bus.in_data, 120'd0};
                    w_word_wr.pvld = 1'b1;
                    w_word_wr.ptr  = make_ptr(bus.in_portmap, 8'd1);
                    state_d        = ST_IDLE;
                end else begin
                    state_d    = ST_PACK;
                    portmap_d  = bus.in_portmap;
                    word_d     = {bus.in_data, 120'd0};
                    byte_idx_d = 4'd1;
                end
            end else begin
                w_drop_inc = 1'b1;
                state_d    = bus.in_eop ? ST_IDLE : ST_DISCARD;
            end
        end else if (bus.in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    w_err_inc = 1'b1;
                end
                ST_DISCARD: begin
                    if (bus.in_eop) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PACK: begin
                    if (wcnt_q == c_max_words) begin
                        if (!trunc_q) begin
                            w_trunc_inc = 1'b1;
                            trunc_d     = 1'b1;
                        end
                        if (bus.in_eop) begin
                            w_word_wr.pvld = 1'b1;
                            w_word_wr.ptr  = make_ptr(portmap_q, wcnt_q);
                        end
                    end else if ((byte_idx_q == 4'd15) || bus.in_eop) begin
                        w_word_wr.dvld = 1'b1;
                        w_word_wr.data = w_packed;
                        w_word_wr.pvld = bus.in_eop;
                        w_word_wr.ptr  = bus.in_eop ? make_ptr(portmap_q, wcnt_q + 8'd1) : 16'd0;
                        word_d         = '0;
                        byte_idx_d     = '0;
                        wcnt_d         = wcnt_q + 8'd1;
                    end else begin
                        word_d     = w_packed;
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                    if (bus.in_eop) begin
                        state_d    = ST_IDLE;
                        word_d     = '0;
                        byte_idx_d = '0;
                        wcnt_d     = '0;
                        trunc_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A closing frame and a new single-byte frame can land in the same cycle;
    // the second write is parked one cycle in pend_q to keep the port single-issue.
    assign w_close_vld = w_close.dvld | w_close.pvld;
    assign w_word_vld  = w_word_wr.dvld | w_word_wr.pvld;
    assign w_pend_vld  = pend_q.dvld | pend_q.pvld;

    always_comb begin
        out_d  = '0;
        pend_d = '0;
        if (w_pend_vld) begin
            out_d  = pend_q;
            pend_d = w_word_wr;
        end else if (w_close_vld && w_word_vld) begin
            out_d  = w_close;
            pend_d = w_word_wr;
        end else if (w_close_vld) begin
            out_d  = w_close;
        end else begin
            out_d  = w_word_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            portmap_q  <= '0;
            byte_idx_q <= '0;
            wcnt_q     <= '0;
            word_q     <= '0;
            trunc_q    <= 1'b0;
            pend_q     <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            portmap_q  <= portmap_d;
            byte_idx_q <= byte_idx_d;
            wcnt_q     <= wcnt_d;
            word_q     <= word_d;
            trunc_q    <= trunc_d;
            pend_q     <= pend_d;
            out_q      <= out_d;
        end
    end

    assign bus.cell_data_wr  = out_q.dvld;
    assign bus.cell_data_din = out_q.data;
    assign bus.cell_ptr_wr   = out_q.pvld;
    assign bus.cell_ptr_din  = out_q.ptr;

    // Frames are counted as their descriptor is issued
    swc_stat_cnt u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (out_d.pvld),
        .cnt_o (bus.stat_frame_cnt)
    );

    swc_stat_cnt u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_drop_inc),
        .cnt_o (bus.stat_drop_cnt)
    );

    swc_stat_cnt u_trunc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_trunc_inc),
        .cnt_o (bus.stat_trunc_cnt)
    );

    swc_stat_cnt u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_err_inc),
        .cnt_o (bus.stat_err_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_swc_ingress_packer.sv
//==============================================================================
// Module      : tb_swc_ingress_packer
// Description : Directed self-checking bench for swc_ingress_packer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_swc_ingress_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    logic [127:0] dlog[$];
    int           dcyc[$];
    logic [15:0]  plog[$];
    int           pcyc[$];

    swc_ingress_packer_if bus ();

    swc_ingress_packer #(.MAX_WORDS(96)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every write strobe together with the cycle it was seen in
    always @(negedge clk) begin
        if (bus.cell_data_wr) begin
            dlog.push_back(bus.cell_data_din);
            dcyc.push_back(cyc);
        end
        if (bus.cell_ptr_wr) begin
            plog.push_back(bus.cell_ptr_din);
            pcyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic sop, input logic eop,
                         input logic [3:0] pm, input logic bp);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_sop     = sop;
        bus.in_eop     = eop;
        bus.in_portmap = pm;
        bus.cell_bp    = bp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_sop   = 1'b0;
            bus.in_eop   = 1'b0;
            bus.cell_bp  = 1'b0;
        end
    endtask

    task automatic send_frame(input int len, input int start, input logic [3:0] pm,
                              input logic bp, input int gap, input bit with_eop);
        for (int i = 0; i < len; i++) begin
            drive(8'(start + i), (i == 0), (with_eop && (i == len - 1)), pm, bp);
            if (gap > 0) idle(gap);
        end
        idle(1);
    endtask

    initial begin : stim
        int d0;
        int p0;
        int c0;

        bus.in_valid   = 1'b0;
        bus.in_data    = 8'd0;
        bus.in_sop     = 1'b0;
        bus.in_eop     = 1'b0;
        bus.in_portmap = 4'd0;
        bus.cell_bp    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data_wr", 128'(bus.cell_data_wr), 128'd0);
        chk("rst_ptr_wr", 128'(bus.cell_ptr_wr), 128'd0);
        chk("rst_data_din", bus.cell_data_din, 128'd0);
        chk("rst_ptr_din", 128'(bus.cell_ptr_din), 128'd0);
        chk("rst_frame_cnt", 128'(bus.stat_frame_cnt), 128'd0);
        rst = 1'b0;
        idle(2);

        // 64-byte frame
        d0 = dlog.size(); p0 = plog.size();
        send_frame(64, 8'h00, 4'b0010, 1'b0, 0, 1'b1);
        idle(3);
        chk("f64_nwords", 128'(dlog.size() - d0), 128'd4);
        chk("f64_word0", dlog[d0], 128'h000102030405060708090a0b0c0d0e0f);
        chk("f64_word3", dlog[d0+3], 128'h303132333435363738393a3b3c3d3e3f);
        chk("f64_spacing", 128'(dcyc[d0+1] - dcyc[d0]), 128'd16);
        chk("f64_nptr", 128'(plog.size() - p0), 128'd1);
        chk("f64_ptr", 128'(plog[p0]), 128'h0204);
        chk("f64_ptr_cyc", 128'(pcyc[p0] - dcyc[d0+3]), 128'd0);
        chk("f64_frames", 128'(bus.stat_frame_cnt), 128'd1);

        // Single-byte frame
        d0 = dlog.size(); p0 = plog.size();
        drive(8'hAB, 1'b1, 1'b1, 4'b1000, 1'b0);
        c0 = cyc;
        idle(3);
        chk("f1_word", dlog[d0], 128'hAB << 120);
        chk("f1_ptr", 128'(plog[p0]), 128'h0801);
        chk("f1_data_cyc", 128'(dcyc[d0] - c0), 128'd1);
        chk("f1_ptr_cyc", 128'(pcyc[p0] - c0), 128'd1);
        chk("f1_frames", 128'(bus.stat_frame_cnt), 128'd2);

        // Back-pressured frame then a normal one
        d0 = dlog.size(); p0 = plog.size();
        send_frame(100, 8'h00, 4'b0001, 1'b1, 0, 1'b1);
        idle(2);
        chk("bp_no_data", 128'(dlog.size() - d0), 128'd0);
        chk("bp_no_ptr", 128'(plog.size() - p0), 128'd0);
        chk("bp_drop_cnt", 128'(bus.stat_drop_cnt), 128'd1);
        send_frame(20, 8'h80, 4'b0101, 1'b0, 0, 1'b1);
        idle(3);
        chk("bp_next_nwords", 128'(dlog.size() - d0), 128'd2);
        chk("bp_next_word0", dlog[d0], 128'h808182838485868788898a8b8c8d8e8f);
        chk("bp_next_word1", dlog[d0+1], 128'h90919293 << 96);
        chk("bp_next_ptr", 128'(plog[p0]), 128'h0502);
        chk("bp_frames", 128'(bus.stat_frame_cnt), 128'd3);

        // Oversized frame truncated at 96 words
        d0 = dlog.size(); p0 = plog.size();
        send_frame(2000, 8'h00, 4'b0100, 1'b0, 0, 1'b1);
        idle(3);
        chk("trunc_nwords", 128'(dlog.size() - d0), 128'd96);
        chk("trunc_last_word", dlog[d0+95], 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
        chk("trunc_ptr", 128'(plog[p0]), 128'h0460);
        chk("trunc_cnt", 128'(bus.stat_trunc_cnt), 128'd1);

        // 17-byte frame with gaps, closed by a new sop
        d0 = dlog.size(); p0 = plog.size();
        send_frame(17, 8'h10, 4'b0011, 1'b0, 1, 1'b0);
        send_frame(5, 8'hC0, 4'b1001, 1'b0, 0, 1'b1);
        idle(3);
        chk("miss_nwords", 128'(dlog.size() - d0), 128'd3);
        chk("miss_word0", dlog[d0], 128'h101112131415161718191a1b1c1d1e1f);
        chk("miss_word1", dlog[d0+1], 128'h20 << 120);
        chk("miss_ptr_old", 128'(plog[p0]), 128'h0302);
        chk("miss_word_new", dlog[d0+2], 128'hc0c1c2c3c4 << 88);
        chk("miss_ptr_new", 128'(plog[p0+1]), 128'h0901);
        chk("miss_err_cnt", 128'(bus.stat_err_cnt), 128'd1);
        chk("miss_frames", 128'(bus.stat_frame_cnt), 128'd6);

        // Reset in the middle of a frame
        d0 = dlog.size(); p0 = plog.size();
        for (int i = 0; i < 40; i++) drive(8'(8'h40 + i), (i == 0), 1'b0, 4'b0001, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_data_wr", 128'(bus.cell_data_wr), 128'd0);
        chk("mrst_ptr_din", 128'(bus.cell_ptr_din), 128'd0);
        chk("mrst_frame_cnt", 128'(bus.stat_frame_cnt), 128'd0);
        chk("mrst_trunc_cnt", 128'(bus.stat_trunc_cnt), 128'd0);
        chk("mrst_err_cnt", 128'(bus.stat_err_cnt), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        chk("mrst_pre_words", 128'(dlog.size() - d0), 128'd2);
        chk("mrst_no_ptr", 128'(plog.size() - p0), 128'd0);
        d0 = dlog.size(); p0 = plog.size();
        send_frame(3, 8'hD0, 4'b0110, 1'b0, 0, 1'b1);
        idle(3);
        chk("mrst_next_word", dlog[d0], 128'hd0d1d2 << 104);
        chk("mrst_next_ptr", 128'(plog[p0]), 128'h0601);
        chk("mrst_next_frames", 128'(bus.stat_frame_cnt), 128'd1);

        // Stray byte in IDLE, then sop+eop with an empty portmap
        d0 = dlog.size(); p0 = plog.size();
        drive(8'h55, 1'b0, 1'b0, 4'b0001, 1'b0);
        drive(8'h66, 1'b1, 1'b1, 4'b0000, 1'b0);
        idle(3);
        chk("stray_err_cnt", 128'(bus.stat_err_cnt), 128'd1);
        chk("pm0_drop_cnt", 128'(bus.stat_drop_cnt), 128'd1);
        chk("pm0_no_data", 128'(dlog.size() - d0), 128'd0);
        chk("pm0_no_ptr", 128'(plog.size() - p0), 128'd0);
        // Next frame must not be lost to a spurious DISCARD state
        send_frame(2, 8'hE0, 4'b1111, 1'b0, 0, 1'b1);
        idle(3);
        chk("pm0_next_ptr", 128'(plog[p0]), 128'h0f01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/swc_ingress_packer.md
SWC_INGRESS_PACKER -- requirements
Module: swc_ingress_packer

Interface
REQ-001 Parameter MAX_WORDS, default 96, sets the maximum 128-bit words per frame (range 1..255); bytes beyond this limit are truncated.
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_data  input  8  frame byte; the first byte of a frame is its byte 0.
REQ-005 in_valid  input  1  in_data is valid this cycle; the stream cannot be stalled (no ready).
REQ-006 in_sop  input  1  first byte of a frame; qualified by in_valid.
REQ-007 in_eop  input  1  last byte of a frame; qualified by in_valid; may coincide with in_sop.
REQ-008 in_portmap  input  4  destination port bitmap; sampled only on a valid sop.
REQ-009 cell_data_din  output  128  packed data word for the switch-core data FIFO.
REQ-010 cell_data_wr  output  1  one-cycle write strobe for cell_data_din.
REQ-011 cell_ptr_din  output  16  frame descriptor: [15:12]=0, [11:8]=portmap, [7:0]=word count.
REQ-012 cell_ptr_wr  output  1  one-cycle write strobe for cell_ptr_din.
REQ-013 cell_bp  input  1  switch-core back-pressure; evaluated only at sop.
REQ-014 stat_frame_cnt, stat_drop_cnt, stat_trunc_cnt, stat_err_cnt  output  16 each  saturating event counters.

Function
REQ-015 The FSM SHALL have states IDLE, PACK and DISCARD.
REQ-016 IDLE, on valid sop with cell_bp=0 and in_portmap!=0: latch in_portmap, load the byte into lane 0, set byte index to 1 and word count to 0, go to PACK.
REQ-017 IDLE, on valid sop with cell_bp=1 or in_portmap=0: go to DISCARD, increment stat_drop_cnt, write nothing.
REQ-018 A single-byte frame (sop and eop together, accepted) SHALL write one data word and its ptr in the next cycle and stay in IDLE.
REQ-019 Byte k of a word SHALL occupy cell_data_din[127-8k -: 8]; unfilled lanes of the final word SHALL be zero.
REQ-020 On acceptance of the 16th byte of a word, cell_data_wr SHALL pulse in the next cycle with that word, and the word count SHALL increment.
REQ-021 On eop in PACK, the partial or full word SHALL be written in the next cycle, with cell_ptr_wr asserted in that same cycle; word count = ceil(bytes/16); stat_frame_cnt increments; return to IDLE.
REQ-022 cell_ptr_wr SHALL never precede the last cell_data_wr of its frame.
REQ-023 When the word count reaches MAX_WORDS, further bytes SHALL be dropped without writing until eop; the ptr is written at eop with count MAX_WORDS; stat_trunc_cnt increments once.
REQ-024 cell_bp SHALL be ignored after sop acceptance; frames are never aborted mid-stream.
REQ-025 DISCARD SHALL return to IDLE on valid eop; a valid sop with eop in the same cycle in IDLE never enters DISCARD.
REQ-026 A valid sop in PACK (missing eop) SHALL close the current frame as in REQ-021, increment stat_err_cnt, and start the new frame per REQ-016/017 in the same cycle.
REQ-027 A valid byte in IDLE without sop SHALL be ignored and SHALL increment stat_err_cnt.
REQ-028 Bytes with in_valid=0 SHALL have no effect; gaps are allowed anywhere within a frame.
REQ-029 All counters SHALL saturate at 16'hFFFF.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While rst=1: FSM in IDLE; cell_data_wr=0, cell_ptr_wr=0, cell_data_din=0, cell_ptr_din=0; all stat counters=0; byte index and word count=0.
REQ-032 Reset mid-frame SHALL discard the partial frame with no ptr write; the bytes following reset are ignored until the next sop.

Structure
REQ-033 Shared package swc_pkg SHALL hold the ptr field positions (PORTMAP 11:8, WCNT 7:0), CELL_WORDS=4 and the state encoding.
REQ-034 One sub-module, swc_stat_cnt (16-bit saturating counter with inc and rst), SHALL be instantiated four times; the rest is flat.

Verification
REQ-035 64-byte frame 0x00..0x3F, portmap 4'b0010, bp=0 -> 4 data writes, first = 128'h000102...0F, then ptr 16'h0204 in the same cycle as the 4th write.
REQ-036 1-byte frame 0xAB (sop=eop), portmap 4'b1000 -> one write 128'hAB00..00 plus ptr 16'h0801 in the next cycle.
REQ-037 sop with cell_bp=1, 100-byte frame -> no writes, stat_drop_cnt=1; the next frame with bp=0 is packed normally.
REQ-038 2000-byte frame, MAX_WORDS=96 -> exactly 96 data writes, ptr 16'h_x60 with the frame's portmap, stat_trunc_cnt=1.
REQ-039 17-byte frame with in_valid gaps, then sop without a preceding eop -> ptr count 2, stat_err_cnt=1, the new frame starts cleanly.
REQ-040 rst asserted after 40 bytes of a frame -> no ptr write, all outputs and counters 0, and the next frame is packed correctly.
